bird_physics: RTL and testbench

- Consumes the one-cycle `enable` game-tick strobe from the tick divider.
- Advances the bird's vertical position on each tick: gravity, flap lift, ceiling saturation, ground and pipe collision.
- Sits between input conditioning (flap/restart pulses) and the LED-matrix renderer.
- Drives the bird row, a one-hot column mask and game-state flags.

---
 rtl/bird_pkg.sv | 21 ++
 rtl/bird_physics.sv | 107 ++++++++++
 tb/tb_bird_physics.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bird_pkg.sv
// Shared types and default parameters for the bird vertical-motion block.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    DEAD   = 2'd2
  } bird_state_t;

  localparam int BIRD_ROWS = 16;
  localparam int START_ROW = 7;
  localparam int FLAP_UP   = 2;
  localparam int MAX_FALL  = 2;

  function automatic int row_w(input int rows);
    return $clog2(rows);
  endfunction

  localparam int ROW_W = row_w(BIRD_ROWS);

endpackage

// File: rtl/bird_physics.sv
// Bird vertical motion per game tick: gravity, flap lift, ceiling clamp, ground/pipe death.
// Latency: one cycle from any qualifying input to row/state outputs.
// Backpressure: none; every enable strobe is a tick and is always accepted.
module bird_physics
  import bird_pkg::*;
#(
  parameter int ROWS      = BIRD_ROWS,
  parameter int START_ROW = bird_pkg::START_ROW,
  parameter int FLAP_UP   = bird_pkg::FLAP_UP,
  parameter int MAX_FALL  = bird_pkg::MAX_FALL
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    flap,
  input  logic                    restart,
  input  logic [ROWS-1:0]         pipe_col,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [ROWS-1:0]         bird_mask,
  output logic                    playing,
  output logic                    game_over
);

  localparam int RW = row_w(ROWS);

  // One extra bit so row + fall_speed cannot wrap before the ground test.
  localparam logic [RW:0]   FLAP_X  = (RW+1)'(FLAP_UP);
  localparam logic [RW:0]   MAXF_X  = (RW+1)'(MAX_FALL);
  localparam logic [RW:0]   LAST_X  = (RW+1)'(ROWS-1);
  localparam logic [RW:0]   ONE_X   = (RW+1)'(1);
  localparam logic [RW-1:0] LAST_R  = RW'(ROWS-1);
  localparam logic [RW-1:0] START_R = RW'(START_ROW);

  bird_state_t   state;
  logic          flap_pending;
  logic [RW:0]   fall_speed;
  logic [RW:0]   row_ext;
  logic [RW:0]   up_ext;
  logic [RW:0]   down_ext;
  logic [RW:0]   next_ext;
  logic [RW:0]   fall_next;
  logic          use_flap;
  logic          hit;

  assign hit = pipe_col[row];

  always_comb begin
    row_ext   = {1'b0, row};
    up_ext    = (row_ext > FLAP_X) ? row_ext - FLAP_X : '0;
    down_ext  = row_ext + fall_speed;
    use_flap  = flap_pending | flap;
    next_ext  = use_flap ? up_ext : down_ext;
    fall_next = use_flap ? ONE_X
              : ((fall_speed >= MAXF_X) ? MAXF_X : fall_speed + ONE_X);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      row          <= START_R;
      fall_speed   <= ONE_X;
      flap_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flap) begin
            state        <= FLYING;
            fall_speed   <= ONE_X;
            flap_pending <= 1'b0;
          end
        end
        FLYING: begin
          // Collision wins over a same-cycle tick: row stays where it was hit.
          if (hit) begin
            state        <= DEAD;
            flap_pending <= 1'b0;
          end else if (enable) begin
            flap_pending <= 1'b0;
            fall_speed   <= fall_next;
            if (next_ext >= LAST_X) begin
              row   <= LAST_R;
              state <= DEAD;
            end else begin
              row <= next_ext[RW-1:0];
            end
          end else if (flap) begin
            flap_pending <= 1'b1;
          end
        end
        DEAD: begin
          if (restart) begin
            state        <= IDLE;
            row          <= START_R;
            fall_speed   <= ONE_X;
            flap_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bird_mask = ROWS'(1) << row;
  assign playing   = (state == FLYING);
  assign game_over = (state == DEAD);

endmodule

// File: tb/tb_bird_physics.sv
// Directed-vector bench: driver queues hand-computed expectations, monitor compares after each edge.
module tb_bird_physics;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic        flap   = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] pipe_col = 16'h0000;
  logic [3:0]  row;
  logic [15:0] bird_mask;
  logic        playing;
  logic        game_over;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int    row;
    logic  play;
    logic  over;
    string nm;
  } exp_t;

  exp_t sb[$];

  bird_physics dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .enable    (enable),
    .flap      (flap),
    .restart   (restart),
    .pipe_col  (pipe_col),
    .row       (row),
    .bird_mask (bird_mask),
    .playing   (playing),
    .game_over (game_over)
  );

  always #5 clk_in = ~clk_in;

  // One cycle of stimulus; the expectation applies after the following rising edge.
  task automatic step(input logic e, input logic f, input logic r, input logic rs,
                      input logic [15:0] p, input int er, input logic ep, input logic eo,
                      input string nm);
    exp_t x;
    @(negedge clk_in);
    enable   = e;
    flap     = f;
    restart  = r;
    reset    = rs;
    pipe_col = p;
    x.row  = er;
    x.play = ep;
    x.over = eo;
    x.nm   = nm;
    sb.push_back(x);
  endtask

  initial begin : monitor
    exp_t        x;
    logic [15:0] em;
    forever begin
      @(posedge clk_in);
      #1;
      if (sb.size() > 0) begin
        x  = sb.pop_front();
        em = 16'h0001 << x.row;
        checks++;
        if (row !== 4'(x.row) || bird_mask !== em || playing !== x.play || game_over !== x.over) begin
          failures++;
          $display("FAIL %s: got row=%0d mask=%h playing=%b game_over=%b, want row=%0d mask=%h playing=%b game_over=%b",
                   x.nm, row, bird_mask, playing, game_over, x.row, em, x.play, x.over);
        end
      end
    end
  end

  initial begin : driver
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h0, 7, 0, 0, "reset");
    // Ticks are ignored in IDLE.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 16'h0, 7, 0, 0, "idle_tick");

    // Free fall from start row to the ground.
    step(0, 1, 0, 0, 16'h0, 7, 1, 0, "idle_flap");
    step(1, 0, 0, 0, 16'h0, 8, 1, 0, "fall1");
    step(1, 0, 0, 0, 16'h0, 10, 1, 0, "fall2");
    step(1, 0, 0, 0, 16'h0, 12, 1, 0, "fall3");
    step(1, 0, 0, 0, 16'h0, 14, 1, 0, "fall4");
    step(1, 0, 0, 0, 16'h0, 15, 0, 1, "ground");
    step(1, 0, 0, 0, 16'h0, 15, 0, 1, "dead_tick");
    step(1, 0, 0, 0, 16'h0, 15, 0, 1, "dead_tick2");

    // DEAD ignores flap and pipes; restart returns to IDLE; restart in IDLE is a no-op.
    step(0, 1, 0, 0, 16'h0, 15, 0, 1, "dead_flap");
    step(1, 0, 0, 0, 16'h8000, 15, 0, 1, "dead_pipe");
    step(0, 0, 1, 0, 16'h0, 7, 0, 0, "restart");
    step(0, 0, 1, 0, 16'h0, 7, 0, 0, "idle_restart");

    // Climb to the ceiling with flap+tick in the same cycle.
    step(0, 1, 0, 0, 16'h0, 7, 1, 0, "launch");
    step(1, 1, 0, 0, 16'h0, 5, 1, 0, "climb1");
    step(1, 1, 0, 0, 16'h0, 3, 1, 0, "climb2");
    step(1, 1, 0, 0, 16'h0, 1, 1, 0, "climb3");
    step(0, 0, 1, 0, 16'h0, 1, 1, 0, "fly_restart");
    step(0, 0, 0, 0, 16'h8000, 1, 1, 0, "pipe_miss");
    step(1, 1, 0, 0, 16'h0, 0, 1, 0, "ceiling");
    step(1, 0, 0, 0, 16'h0, 1, 1, 0, "off_ceiling");
    step(1, 0, 0, 0, 16'h0, 3, 1, 0, "fall_a");
    step(1, 0, 0, 0, 16'h0, 5, 1, 0, "fall_b");
    step(1, 0, 0, 0, 16'h0, 7, 1, 0, "fall_c");

    // Pipe hit at row 7 beats a simultaneous tick.
    step(1, 0, 0, 0, 16'h0080, 7, 0, 1, "pipe_hit");
    step(1, 0, 0, 0, 16'h0080, 7, 0, 1, "pipe_hold");

    // Pending flap, then reset mid-flight at row 12.
    step(0, 0, 1, 0, 16'h0, 7, 0, 0, "restart2");
    step(0, 1, 0, 0, 16'h0, 7, 1, 0, "launch2");
    step(1, 0, 0, 0, 16'h0, 8, 1, 0, "drop1");
    step(1, 0, 0, 0, 16'h0, 10, 1, 0, "drop2");
    step(1, 0, 0, 0, 16'h0, 12, 1, 0, "drop3");
    step(0, 1, 0, 0, 16'h0, 12, 1, 0, "pend_at12");
    step(0, 0, 0, 1, 16'h0, 7, 0, 0, "midflight_reset");
    step(1, 0, 0, 0, 16'h0, 7, 0, 0, "post_reset_tick");

    // A pending flap is consumed by the next tick.
    step(0, 1, 0, 0, 16'h0, 7, 1, 0, "launch3");
    step(1, 0, 0, 0, 16'h0, 8, 1, 0, "tick_a");
    step(0, 1, 0, 0, 16'h0, 8, 1, 0, "pend_flap");
    step(1, 0, 0, 0, 16'h0, 6, 1, 0, "pend_used");
    step(1, 0, 0, 0, 16'h0, 7, 1, 0, "pend_cleared");

    @(negedge clk_in);
    enable = 0; flap = 0; restart = 0; pipe_col = 16'h0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
